// File: rtl/serial_dp_sched.sv
// Round-robin scheduler sharing one bit-serial datapath among NREQ requesters.
// Per grant: latch the word, clear the datapath, shift it out LSB-first, collect WIDTH result bits.
module serial_dp_sched #(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned LAT   = 1,
    localparam int unsigned IDW   = $clog2(NREQ),
    localparam int unsigned CW    = $clog2(WIDTH + LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [WIDTH-1:0]      rdata,
    output logic                  dp_a,
    output logic                  dp_clr,
    input  logic                  dp_w
);

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             dp_a_q, dp_a_d;

    logic             any_req;
    logic [IDW-1:0]   win;
    logic [NREQ-1:0]  win_oh;
    logic [WIDTH-1:0] win_word;

    // First requesting index at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!any_req && req[IDW'((32'(rr_q) + k) % NREQ)]) begin
                any_req = 1'b1;
                win     = IDW'((32'(rr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
        win_word    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_word = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rdata_d = rdata_q;
        dp_a_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sh_d    = win_word;
                    id_d    = win;
                    rr_d    = IDW'((32'(win) + 1) % NREQ);
                    state_d = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                dp_a_d  = sh_q[0];
                sh_d    = sh_q >> 1;
                state_d = RUN;
            end
            RUN: begin
                // Shifting in zeros keeps dp_a low once the word is exhausted.
                dp_a_d = sh_q[0];
                sh_d   = sh_q >> 1;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CW'(i + LAT)) begin
                        rdata_d[i] = dp_w;
                    end
                end
                if (cnt_q == CW'(WIDTH + LAT - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            rdata_q <= '0;
            dp_a_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rdata_q <= rdata_d;
            dp_a_q  <= dp_a_d;
        end
    end

    // Grant is gated by rst so a held request cannot leak out during reset.
    assign gnt     = (rst && (state_q == IDLE) && any_req) ? win_oh : '0;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign dp_clr  = (state_q == CLR);
    assign dp_a    = dp_a_q;
    assign done_id = id_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_serial_dp_sched.sv
// Bench for serial_dp_sched: LAT=1 instance against a transaction-timeline model,
// plus a LAT=3 instance with a 3-flop loopback for latency/period checks.
`timescale 1ns/1ps
module tb_serial_dp_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned L    = 1;
    localparam int unsigned P    = W + L + 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            inv = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [W-1:0]    wd [NREQ];
    logic [NREQ*W-1:0] wdata;
    logic [NREQ-1:0] gnt;
    logic            busy, done, dp_a, dp_clr, dp_w;
    logic [1:0]      done_id;
    logic [W-1:0]    rdata;

    logic [NREQ-1:0]   reqb   = '0;
    logic [NREQ*W-1:0] wdatab = '0;
    logic [NREQ-1:0]   b_gnt;
    logic              b_busy, b_done, b_dp_a, b_dp_clr, b_dp_w;
    logic [1:0]        b_done_id;
    logic [W-1:0]      b_rdata;

    logic       lb1 = 1'b0;
    logic [2:0] lb3 = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        lb1 <= dp_a;
        lb3 <= {lb3[1:0], b_dp_a};
    end
    assign dp_w   = lb1 ^ inv;
    assign b_dp_w = lb3[2];

    always_comb begin
        for (int i = 0; i < NREQ; i++) wdata[i*W +: W] = wd[i];
    end

    serial_dp_sched #(.NREQ(NREQ), .WIDTH(W), .LAT(L)) u_dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt), .busy(busy),
        .done(done), .done_id(done_id), .rdata(rdata), .dp_a(dp_a), .dp_clr(dp_clr), .dp_w(dp_w)
    );

    serial_dp_sched #(.NREQ(NREQ), .WIDTH(W), .LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(reqb), .wdata(wdatab), .gnt(b_gnt), .busy(b_busy),
        .done(b_done), .done_id(b_done_id), .rdata(b_rdata), .dp_a(b_dp_a), .dp_clr(b_dp_clr),
        .dp_w(b_dp_w)
    );

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: one active transaction described by its grant cycle and word.
    logic            t_valid = 1'b0;
    int unsigned     t_g = 0, t_id = 0, rr_m = 0;
    logic [W-1:0]    t_word = '0, t_res = '0, last_res = '0;
    logic [NREQ-1:0] hold = '0, last_gnt = '0;
    bit              rand_mode = 1'b0;

    int unsigned gq[$], gcyc[$], dq[$], did[$], dcyc[$];
    int unsigned bg[$], bgid[$], bd[$], bdr[$], bdid[$];

    function automatic int unsigned rr_pick(input logic [NREQ-1:0] r, input int unsigned p);
        logic [2*NREQ-1:0] dbl;
        dbl = {r, r} >> p;
        for (int unsigned k = 0; k < NREQ; k++) if (dbl[k]) return (p + k) % NREQ;
        return 0;
    endfunction

    function automatic int unsigned oh2id(input logic [NREQ-1:0] v);
        for (int unsigned i = 0; i < NREQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic clear_q();
        gq.delete(); gcyc.delete(); dq.delete(); did.delete(); dcyc.delete();
    endtask

    task automatic step_in();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (last_gnt[i] && !hold[i]) req[i] = 1'b0;
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    wd[i]  = W'($urandom);
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic step_chk();
        logic [NREQ-1:0] e_gnt;
        logic e_busy, e_done, e_clr, e_a;
        int unsigned off, w;
        @(negedge clk);
        cyc++;
        e_gnt = '0; e_busy = 1'b0; e_done = 1'b0; e_clr = 1'b0; e_a = 1'b0; off = 0;
        if (!rst) begin
            t_valid = 1'b0; rr_m = 0; last_res = '0;
        end else begin
            if (t_valid) begin
                off = cyc - t_g;
                if (off >= P) t_valid = 1'b0;
            end
            if (t_valid) begin
                e_busy = 1'b1;
                e_clr  = (off == 1);
                e_done = (off == P - 1);
                if (off >= 2 && off - 2 < W) e_a = t_word[off-2];
            end else if (req != '0) begin
                w = rr_pick(req, rr_m);
                e_gnt[w] = 1'b1;
                t_valid = 1'b1; t_g = cyc; t_id = w; t_word = wd[w];
                t_res = inv ? ~wd[w] : wd[w];
                rr_m = (w + 1) % NREQ;
            end
        end
        check_eq("gnt", gnt, e_gnt);
        check_eq("busy", busy, e_busy);
        check_eq("done", done, e_done);
        check_eq("dp_clr", dp_clr, e_clr);
        check_eq("dp_a", dp_a, e_a);
        if (!rst) begin
            check_eq("rst_rdata", rdata, 0);
            check_eq("rst_done_id", done_id, 0);
        end else if (e_done) begin
            check_eq("rdata", rdata, t_res);
            check_eq("done_id", done_id, t_id);
            last_res = t_res;
        end else if (!e_busy) begin
            check_eq("rdata_hold", rdata, last_res);
        end
        last_gnt = gnt;
        if (gnt != '0) begin gq.push_back(oh2id(gnt)); gcyc.push_back(cyc); end
        if (done) begin dq.push_back(rdata); did.push_back(done_id); dcyc.push_back(cyc); end
        if (b_gnt != '0) begin bg.push_back(cyc); bgid.push_back(oh2id(b_gnt)); end
        if (b_done) begin bd.push_back(cyc); bdr.push_back(b_rdata); bdid.push_back(b_done_id); end
    endtask

    task automatic advance();
        step_in();
        step_chk();
    endtask

    task automatic run_until(input int unsigned ndone, input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (dq.size() < ndone && n < budget) begin advance(); n++; end
        if (dq.size() < ndone) check_eq({tag, "_timeout"}, dq.size(), ndone);
    endtask

    task automatic do_reset();
        step_in(); rst = 1'b0; req = '0; hold = '0; step_chk();
        advance();
        step_in(); rst = 1'b1; step_chk();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NREQ; i++) wd[i] = '0;

        // Reset with requests pending on both instances: everything must stay quiet.
        step_in(); req = 4'b1011; reqb = 4'b0001; step_chk();
        check_eq("rst_b_gnt", b_gnt, 0);
        check_eq("rst_b_busy", b_busy, 0);
        check_eq("rst_b_done", b_done, 0);
        check_eq("rst_b_clr", b_dp_clr, 0);
        check_eq("rst_b_a", b_dp_a, 0);
        check_eq("rst_b_rdata", b_rdata, 0);
        check_eq("rst_b_id", b_done_id, 0);
        step_in(); req = '0; reqb = '0; rst = 1'b1; step_chk();

        // Single 0xA5 transaction through the plain loopback.
        step_in(); clear_q(); wd[0] = 8'hA5; req = 4'b0001; step_chk();
        run_until(1, 30, "a5");
        if (gq.size() > 0 && dq.size() > 0) begin
            check_eq("a5_gnt_id", gq[0], 0);
            check_eq("a5_latency", dcyc[0] - gcyc[0], 11);
            check_eq("a5_rdata", dq[0], 8'hA5);
            check_eq("a5_id", did[0], 0);
        end

        // All four requesting from a fresh pointer.
        do_reset();
        step_in(); clear_q();
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44; req = 4'b1111;
        step_chk();
        run_until(4, 60, "all4");
        if (gq.size() >= 4 && dq.size() >= 4) begin
            for (int unsigned k = 0; k < 4; k++) begin
                check_eq("all4_order", gq[k], k);
                check_eq("all4_spacing", gcyc[k] - gcyc[0], 12 * k);
                check_eq("all4_rdata", dq[k], 32'h11 * (k + 1));
                check_eq("all4_id", did[k], k);
            end
        end

        // Requesters 0 and 2 held continuously.
        step_in(); clear_q(); wd[0] = 8'h5A; wd[2] = 8'hC7; hold = 4'b0101; req = 4'b0101; step_chk();
        for (int n = 0; n < 100 && gq.size() < 6; n++) advance();
        check_eq("alt_count", gq.size(), 6);
        if (gq.size() >= 6) begin
            for (int unsigned k = 0; k < 6; k++) check_eq("alt_order", gq[k], (k % 2) * 2);
        end
        step_in(); hold = '0; req = '0; step_chk();
        repeat (P) advance();

        // Inverting loopback.
        step_in(); clear_q(); inv = 1'b1; wd[1] = 8'h3C; req = 4'b0010; step_chk();
        run_until(1, 30, "inv");
        if (dq.size() > 0) begin
            check_eq("inv_rdata", dq[0], 8'hC3);
            check_eq("inv_id", did[0], 1);
        end
        step_in(); inv = 1'b0; step_chk();

        // Random requests, holds and withdrawals.
        step_in(); rand_mode = 1'b1; step_chk();
        repeat (400) advance();
        step_in(); rand_mode = 1'b0; req = '0; step_chk();
        repeat (P) advance();

        // Reset in the middle of a transaction with 0 and 1 pending.
        step_in(); clear_q(); wd[0] = W'($urandom); wd[1] = W'($urandom);
        hold = 4'b0011; req = 4'b0011; step_chk();
        for (int n = 0; n < 20 && gq.size() == 0; n++) advance();
        check_eq("mid_grant_seen", gq.size(), 1);
        repeat (5) advance();
        rst = 1'b0;
        #1;
        check_eq("mid_gnt", gnt, 0);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_done", done, 0);
        check_eq("mid_clr", dp_clr, 0);
        check_eq("mid_a", dp_a, 0);
        check_eq("mid_rdata", rdata, 0);
        check_eq("mid_id", done_id, 0);
        advance();
        advance();
        step_in(); rst = 1'b1; hold = '0; clear_q(); step_chk();
        run_until(1, 30, "mid");
        if (gq.size() > 0 && dq.size() > 0) begin
            check_eq("mid_first_gnt", gq[0], 0);
            check_eq("mid_done_id", did[0], 0);
            check_eq("mid_rdata_after", dq[0], wd[0]);
        end
        step_in(); req = '0; step_chk();
        repeat (P + 1) advance();

        // LAT=3 instance: latency and period.
        step_in(); bg.delete(); bd.delete(); bdr.delete(); bdid.delete(); bgid.delete();
        wdatab = '0; wdatab[7:0] = 8'h81; reqb = 4'b0001; step_chk();
        for (int n = 0; n < 60 && bd.size() < 2; n++) advance();
        check_eq("l3_dones", bd.size() >= 2, 1);
        if (bg.size() >= 2 && bd.size() >= 1) begin
            check_eq("l3_gnt_id", bgid[0], 0);
            check_eq("l3_latency", bd[0] - bg[0], 13);
            check_eq("l3_period", bg[1] - bg[0], 14);
            check_eq("l3_rdata", bdr[0], 8'h81);
            check_eq("l3_id", bdid[0], 0);
        end
        step_in(); reqb = '0; step_chk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
